// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file : RV32I integer register file
//
// Holds NREG architectural registers of XLEN bits each. There are two
// combinational read ports and one write port that updates on the rising clock
// edge. Register x0 always reads zero, and writes to it are dropped.
//
// Ports
//   clk   in   1     system clock; all state updates on the rising edge
//   rst   in   1     asynchronous active-high reset; clears every register
//   we    in   1     write enable, sampled on the rising clk edge
//   rs1   in   5     read port 1 register index
//   rs2   in   5     read port 2 register index
//   rd    in   5     write register index
//   wd    in   XLEN  write data
//   rd1   out  XLEN  read data for rs1
//   rd2   out  XLEN  read data for rs2
//
// Parameters
//   XLEN    register / data width
//   NREG    number of registers (at most 32, because indices are 5 bits).
//           An index >= NREG reads zero, and a write to it is dropped.
//   BYPASS  1 : a write in the current cycle is forwarded to a matching read
//               port (write-through).
//           0 : read ports return only the stored contents.
// -----------------------------------------------------------------------------
module reg_file #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int BYPASS = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   // x0 has no storage at all. Its read value is forced to zero by the read
   // mux below, so only x1..x(NREG-1) are real flops.
   logic [XLEN-1:0] regs [1:NREG-1];

   // A write is architecturally visible only when it targets a real,
   // writable register.
   logic wr_ok;
   assign wr_ok = we && (rd != 5'd0) && (int'(rd) < NREG);

   // NOTE: the storage array is reset explicitly. The register file must never
   // present X after reset, so it is built from flops rather than a RAM macro
   // that has no reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NREG; i++) begin
            // NOTE: use non-blocking assignments for all sequential state, so
            // that other blocks reading regs see the value from before the edge.
            regs[i] <= '0;
         end
      end else if (wr_ok) begin
         for (int i = 1; i < NREG; i++) begin
            if (int'(rd) == i) begin
               regs[i] <= wd;
            end
         end
      end
   end

   // Forwarding is suppressed while rst is high. During reset the ports must
   // read zero, even if a write appears to be pending.
   logic fwd1, fwd2;
   assign fwd1 = (BYPASS != 0) && !rst && wr_ok && (rs1 == rd);
   assign fwd2 = (BYPASS != 0) && !rst && wr_ok && (rs2 == rd);

   // The read muxes are written as explicit compare loops. An index that
   // matches no stored register (x0, or >= NREG) falls through to zero.
   always_comb begin
      // NOTE: give every output a default before the loop, so that no path
      // leaves it unassigned and no latch is inferred.
      rd1 = '0;
      rd2 = '0;
      for (int i = 1; i < NREG; i++) begin
         if (int'(rs1) == i) rd1 = regs[i];
         if (int'(rs2) == i) rd2 = regs[i];
      end
      if (fwd1) rd1 = wd;
      if (fwd2) rd2 = wd;
   end

endmodule

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file : scoreboard bench for reg_file
//
// Two copies of the design share all of their inputs:
//   dut0 is built with BYPASS=0.
//   dut1 is built with BYPASS=1.
//
// For each check, the stimulus process pushes the expected read data for both
// copies onto a queue, then fires an event. A separate monitor process pops the
// queue and compares the four read outputs.
// -----------------------------------------------------------------------------
module tb_reg_file;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            we;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] wd;
   logic [XLEN-1:0] rd1_b0, rd2_b0, rd1_b1, rd2_b1;

   always #5 clk = ~clk;

   reg_file #(.XLEN(XLEN), .NREG(32), .BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .we(we), .rs1(rs1), .rs2(rs2), .rd(rd),
      .wd(wd), .rd1(rd1_b0), .rd2(rd2_b0)
   );

   reg_file #(.XLEN(XLEN), .NREG(32), .BYPASS(1)) dut1 (
      .clk(clk), .rst(rst), .we(we), .rs1(rs1), .rs2(rs2), .rd(rd),
      .wd(wd), .rd1(rd1_b1), .rd2(rd2_b1)
   );

   // One scoreboard entry: a label plus the expected values of rd1 and rd2
   // for the BYPASS=0 copy (e1, e2) and the BYPASS=1 copy (f1, f2).
   typedef struct {
      string           name;
      logic [XLEN-1:0] e1, e2;
      logic [XLEN-1:0] f1, f2;
   } exp_t;

   exp_t q[$];
   event do_check;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [XLEN-1:0] act,
                        input logic [XLEN-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: each request from the stimulus process consumes one entry.
   initial begin
      exp_t e;
      forever begin
         @(do_check);
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got no entry expected one (t=%0t)", $time);
         end else begin
            e = q.pop_front();
            check({e.name, ".b0.rd1"}, rd1_b0, e.e1);
            check({e.name, ".b0.rd2"}, rd2_b0, e.e2);
            check({e.name, ".b1.rd1"}, rd1_b1, e.f1);
            check({e.name, ".b1.rd2"}, rd2_b1, e.f2);
         end
      end
   end

   // Push the expected values and ask the monitor to compare. The trailing #1
   // keeps back-to-back requests in separate time steps.
   task automatic expect_rd(input string name,
                            input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                            input logic [XLEN-1:0] f1, input logic [XLEN-1:0] f2);
      exp_t e;
      e.name = name;
      e.e1 = e1;
      e.e2 = e2;
      e.f1 = f1;
      e.f2 = f2;
      #1;
      q.push_back(e);
      ->do_check;
      #1;
   endtask

   // Advance to 1 ns after the next rising edge, well clear of the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Value written to register i by the full sweep.
   function automatic logic [XLEN-1:0] sweep_val(input int i);
      return (i == 0) ? '0 : XLEN'(i) * 32'h0101_0101;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      we  = 1'b0;
      rs1 = '0;
      rs2 = '0;
      rd  = '0;
      wd  = '0;
      tick();

      // While in reset: no forwarding and no stored data; everything reads 0.
      we  = 1'b1;
      rd  = 5'd5;
      wd  = 32'hCAFE_F00D;
      rs1 = 5'd5;
      rs2 = 5'd5;
      expect_rd("in_reset", 0, 0, 0, 0);
      tick();

      // Release reset mid-cycle. The next edge must perform the write to x5.
      // Before that edge, only the BYPASS=1 copy shows the new value.
      we = 1'b0;
      #2;
      rst = 1'b0;
      we  = 1'b1;
      wd  = 32'h1234_5678;
      expect_rd("x5_pre_edge", 0, 0, 32'h1234_5678, 32'h1234_5678);
      tick();
      we = 1'b0;
      expect_rd("x5_written", 32'h1234_5678, 32'h1234_5678,
                32'h1234_5678, 32'h1234_5678);

      // Assert reset asynchronously mid-cycle. x5 must clear before any edge.
      #1;
      rst = 1'b1;
      expect_rd("async_reset_x5", 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         expect_rd("reset_sweep", 0, 0, 0, 0);
      end
      tick();
      rst = 1'b0;

      // Basic write and read back.
      we = 1'b1;
      rd = 5'd1;
      wd = 32'hAAAA_AAAA;
      tick();
      rd = 5'd2;
      wd = 32'h5555_5555;
      tick();
      we  = 1'b0;
      rs1 = 5'd1;
      rs2 = 5'd2;
      expect_rd("basic_rw", 32'hAAAA_AAAA, 32'h5555_5555,
                32'hAAAA_AAAA, 32'h5555_5555);

      // x0 is hardwired to zero, including while a write to x0 is pending
      // under BYPASS=1.
      we  = 1'b1;
      rd  = 5'd0;
      wd  = 32'hFFFF_FFFF;
      rs1 = 5'd0;
      rs2 = 5'd0;
      expect_rd("x0_during_write", 0, 0, 0, 0);
      tick();
      we = 1'b0;
      expect_rd("x0_after_write", 0, 0, 0, 0);

      // With we=0, x3 must hold its reset value across several edges.
      we  = 1'b0;
      rd  = 5'd3;
      wd  = 32'hDEAD_BEEF;
      rs1 = 5'd3;
      rs2 = 5'd3;
      expect_rd("we_low_same_cycle", 0, 0, 0, 0);
      repeat (3) tick();
      rs2 = 5'd1;
      expect_rd("we_gating", 0, 32'hAAAA_AAAA, 0, 32'hAAAA_AAAA);

      // Same-cycle read and write of x7.
      we = 1'b1;
      rd = 5'd7;
      wd = 32'h1111_1111;
      tick();
      we  = 1'b0;
      rs1 = 5'd7;
      rs2 = 5'd7;
      expect_rd("x7_old", 32'h1111_1111, 32'h1111_1111,
                32'h1111_1111, 32'h1111_1111);
      we = 1'b1;
      wd = 32'h2222_2222;
      expect_rd("x7_during_write", 32'h1111_1111, 32'h1111_1111,
                32'h2222_2222, 32'h2222_2222);
      rs2 = 5'd2;
      expect_rd("x7_fwd_one_port", 32'h1111_1111, 32'h5555_5555,
                32'h2222_2222, 32'h5555_5555);
      tick();
      we  = 1'b0;
      rs2 = 5'd7;
      expect_rd("x7_after_edge", 32'h2222_2222, 32'h2222_2222,
                32'h2222_2222, 32'h2222_2222);

      // Full sweep: write x1..x31 on consecutive edges, then read mirrored
      // index pairs.
      we = 1'b1;
      for (int i = 1; i < 32; i++) begin
         rd = 5'(i);
         wd = sweep_val(i);
         tick();
      end
      we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i);
         rs2 = 5'(31 - i);
         expect_rd($sformatf("sweep_%0d", i), sweep_val(i), sweep_val(31 - i),
                   sweep_val(i), sweep_val(31 - i));
      end

      // Leave the monitor time to drain, then verify that nothing is left.
      #5;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- RV32I integer register file: 32 x 32-bit registers.
- Two combinational read ports and one synchronous write port.
- Sits between decode (rs1/rs2 indices) and execute; writeback drives rd/wd/we.
- Register x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register and of the wd/rd1/rd2 ports.
- NREG, 32, number of architectural registers; index width is clog2(NREG) = 5.
- BYPASS, 0, when 1 a same-cycle write is forwarded to the read ports (write-through); when 0 reads return stored contents only.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset; clears all registers.
- we  in  1  write enable, sampled on rising clk edge.
- rs1  in  5  read port 1 register index.
- rs2  in  5  read port 2 register index.
- rd  in  5  write register index.
- wd  in  XLEN  write data.
- rd1  out  XLEN  read data for rs1.
- rd2  out  XLEN  read data for rs2.

Behaviour:
- Reset: rst high clears registers x0..x31 to 0 immediately, without waiting for clk. While rst is high, no write occurs, and rd1/rd2 read 0 for every index.
- Reset released mid-cycle: the next rising edge with we=1 performs a normal write.
- Write: on a rising clk edge with rst=0 and we=1, reg[rd] <= wd. Latency is one edge. When we=0, all registers hold.
- x0: a write with rd=0 is discarded. reg[0] always reads 0, including under bypass.
- Read: rd1 = reg[rs1] and rd2 = reg[rs2]. Both are purely combinational and update in the same cycle as an index change. There is no read enable.
- Simultaneous read and write to the same index:
  - BYPASS=0: the read returns the old value until the edge, then the new value.
  - BYPASS=1: if we=1 and rd!=0 and rs==rd, the port outputs wd combinationally in that cycle.
- rs1 == rs2: both ports return identical data.
- Out-of-range indices cannot occur with NREG=32. For NREG<32, an index >= NREG reads 0 and a write to it is discarded.
- No X propagation after reset: all outputs are defined once rst has been asserted.
- Storage: a flop array, or an inferred RAM with x0 masked at the read mux, are both acceptable. Behaviour must match the above.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing x5=0x12345678 -> rd1 with rs1=5 drops to 0x00000000 before the next clk edge; all 32 registers read 0.
- Basic write/read: we=1, rd=1, wd=0xAAAAAAAA on one edge; then rd=2, wd=0x55555555 on the next edge; then we=0, rs1=1, rs2=2 -> rd1=0xAAAAAAAA, rd2=0x55555555.
- x0 hardwired: we=1, rd=0, wd=0xFFFFFFFF, then read with rs1=0, rs2=0 -> rd1=rd2=0x00000000.
- Write enable gating: we=0, rd=3, wd=0xDEADBEEF over several edges -> reading rs1=3 returns its prior value (0 after reset).
- Same-cycle read/write of x7 (old value 0x11111111, writing 0x22222222, rs1=7):
  - BYPASS=0: rd1 is 0x11111111 before the edge and 0x22222222 after it.
  - BYPASS=1: rd1 is 0x22222222 during the write cycle.
  - rs1=0 while rd=0 under BYPASS=1 -> 0.
- Full sweep: write x1..x31 with value (i * 0x01010101) on consecutive edges, then read all pairs (rs1=i, rs2=31-i) -> each port returns its index's value and x0 returns 0.
